fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/cpu_types_pkg.sv | 27 ++
 rtl/next_pc_logic.sv | 37 +++
 rtl/fetch_unit.sv | 122 ++++++++++++
 tb/tb_fetch_unit.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared types for the fetch path: machine word, next-PC select encoding and fetch FSM states.
// Also hosts the branch-offset helper so the PC datapath and any later stage agree on it.
package cpu_types_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        PC_NEXT   = 2'b00,
        PC_JUMP   = 2'b01,
        PC_BRANCH = 2'b10,
        PC_JR     = 2'b11
    } pcsrc_t;

    typedef enum logic [1:0] {
        FETCH  = 2'b00,
        MEM    = 2'b01,
        HALTED = 2'b10
    } fetch_state_t;

    // Word offset of a branch: sign-extended immediate scaled to bytes.
    function automatic word_t branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/next_pc_logic.sv
// Next-PC selector: PC+4, jump, branch or register target; purely combinational.
// Zero latency, no flow control; the caller decides when the result is committed.
module next_pc_logic
    import cpu_types_pkg::*;
(
    input  word_t       i_pc,
    input  pcsrc_t      i_pcsrc,
    input  logic [15:0] i_imm,
    input  logic [25:0] i_addr,
    input  word_t       i_rdat1,
    output word_t       o_pc_plus4,
    output word_t       o_next_pc
);

    word_t w_pc_plus4;
    word_t w_jump_tgt;
    word_t w_branch_tgt;

    assign w_pc_plus4   = i_pc + 32'd4;
    // Jump keeps the top nibble of the sequential PC, not of the current one.
    assign w_jump_tgt   = {w_pc_plus4[31:28], i_addr, 2'b00};
    assign w_branch_tgt = w_pc_plus4 + branch_offset(i_imm);

    always_comb begin
        o_next_pc = w_pc_plus4;
        case (i_pcsrc)
            PC_NEXT:   o_next_pc = w_pc_plus4;
            PC_JUMP:   o_next_pc = w_jump_tgt;
            PC_BRANCH: o_next_pc = w_branch_tgt;
            PC_JR:     o_next_pc = i_rdat1;
            default:   o_next_pc = w_pc_plus4;
        endcase
    end

    assign o_pc_plus4 = w_pc_plus4;

endmodule

// File: rtl/fetch_unit.sv
// Multi-cycle fetch/memory sequencer: one instruction retires per ihit (or per dhit for loads/stores).
// Stalls indefinitely on missing ihit/dhit; HALTED freezes PC and count until RST.
module fetch_unit
    import cpu_types_pkg::*;
#(
    parameter word_t PC_INIT = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ihit,
    input  logic        dhit,
    input  logic [1:0]  PCsrc,
    input  logic [15:0] imm,
    input  logic [25:0] addr,
    input  logic [31:0] rdat1,
    input  logic        halt_in,
    input  logic        dREN_in,
    input  logic        dWEN_in,
    output logic [31:0] imemaddr,
    output logic        imemREN,
    output logic        dmemREN,
    output logic        dmemWEN,
    output logic [31:0] pc_plus4,
    output logic        halt,
    output logic [31:0] icount
);

    fetch_state_t r_state;
    fetch_state_t w_state_nxt;
    word_t        r_pc;
    word_t        r_icount;
    logic         r_dren;
    logic         r_dwen;

    word_t        w_next_pc;
    word_t        w_pc_plus4;
    logic         w_retire;
    logic         w_latch_req;

    next_pc_logic u_next_pc (
        .i_pc       (r_pc),
        .i_pcsrc    (pcsrc_t'(PCsrc)),
        .i_imm      (imm),
        .i_addr     (addr),
        .i_rdat1    (rdat1),
        .o_pc_plus4 (w_pc_plus4),
        .o_next_pc  (w_next_pc)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state  <= FETCH;
            r_pc     <= PC_INIT;
            r_icount <= '0;
            r_dren   <= 1'b0;
            r_dwen   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_retire) begin
                r_pc     <= w_next_pc;
                r_icount <= r_icount + 32'd1;
            end
            if (w_latch_req) begin
                r_dren <= dREN_in;
                r_dwen <= dWEN_in;
            end else if (r_state == MEM && dhit) begin
                r_dren <= 1'b0;
                r_dwen <= 1'b0;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_retire    = 1'b0;
        w_latch_req = 1'b0;
        imemREN     = 1'b0;
        dmemREN     = 1'b0;
        dmemWEN     = 1'b0;
        case (r_state)
            FETCH: begin
                imemREN = 1'b1;
                if (ihit) begin
                    if (halt_in) begin
                        w_state_nxt = HALTED;
                    end else if (dREN_in || dWEN_in) begin
                        w_state_nxt = MEM;
                        w_latch_req = 1'b1;
                    end else begin
                        w_retire = 1'b1;
                    end
                end
            end
            MEM: begin
                // Instruction stays in flight: PC is only advanced once the data side completes.
                dmemREN = r_dren;
                dmemWEN = r_dwen;
                if (dhit) begin
                    w_retire    = 1'b1;
                    w_state_nxt = FETCH;
                end
            end
            HALTED: begin
                w_state_nxt = HALTED;
            end
            default: begin
                w_state_nxt = FETCH;
            end
        endcase
        if (RST) begin
            imemREN = 1'b0;
            dmemREN = 1'b0;
            dmemWEN = 1'b0;
        end
    end

    assign imemaddr = r_pc;
    assign pc_plus4 = w_pc_plus4;
    assign halt     = (r_state == HALTED);
    assign icount   = r_icount;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed scenarios plus a randomized run, each checked against a cycle-level behavioural model.
module tb_fetch_unit;

    localparam logic [31:0] PC_INIT = 32'h0000_0000;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        ihit = 1'b0, dhit = 1'b0;
    logic [1:0]  PCsrc = 2'b00;
    logic [15:0] imm = '0;
    logic [25:0] addr = '0;
    logic [31:0] rdat1 = '0;
    logic        halt_in = 1'b0, dREN_in = 1'b0, dWEN_in = 1'b0;
    logic [31:0] imemaddr, pc_plus4, icount;
    logic        imemREN, dmemREN, dmemWEN, halt;

    int n_vec = 0;
    int n_err = 0;

    // Model: 0 = waiting for instruction, 1 = waiting for data, 2 = halted
    int          m_mode = 0;
    logic [31:0] m_pc = PC_INIT;
    logic [31:0] m_ic = 0;
    logic        m_rd = 0, m_wr = 0;

    fetch_unit #(.PC_INIT(PC_INIT)) dut (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .PCsrc(PCsrc),
        .imm(imm), .addr(addr), .rdat1(rdat1), .halt_in(halt_in),
        .dREN_in(dREN_in), .dWEN_in(dWEN_in), .imemaddr(imemaddr),
        .imemREN(imemREN), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
        .pc_plus4(pc_plus4), .halt(halt), .icount(icount)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] model_target();
        logic [31:0] seq;
        seq = m_pc + 32'd4;
        case (PCsrc)
            2'd1:    return (seq & 32'hF000_0000) | (32'(addr) * 32'd4);
            2'd2:    return seq + 32'($signed(imm) * 4);
            2'd3:    return rdat1;
            default: return seq;
        endcase
    endfunction

    // Advance the model by one edge using the present inputs, then clock the DUT.
    task automatic tick();
        if (RST) begin
            m_mode = 0; m_pc = PC_INIT; m_ic = 0; m_rd = 0; m_wr = 0;
        end else if (m_mode == 0 && ihit) begin
            if (halt_in) m_mode = 2;
            else if (dREN_in || dWEN_in) begin
                m_mode = 1; m_rd = dREN_in; m_wr = dWEN_in;
            end else begin
                m_pc = model_target(); m_ic = m_ic + 1;
            end
        end else if (m_mode == 1 && dhit) begin
            m_pc = model_target(); m_ic = m_ic + 1; m_mode = 0;
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        ihit = 0; dhit = 0; PCsrc = 0; halt_in = 0; dREN_in = 0; dWEN_in = 0;
    endtask

    task automatic go_pc(input logic [31:0] tgt);
        idle_inputs();
        ihit = 1; PCsrc = 2'd3; rdat1 = tgt;
        tick();
        idle_inputs();
    endtask

    task automatic test_reset();
        RST = 1; idle_inputs();
        tick(); tick();
        n_vec++; if (imemaddr !== PC_INIT) begin n_err++; $display("FAIL reset_pc got %h want %h", imemaddr, PC_INIT); end
        n_vec++; if (icount !== 32'd0) begin n_err++; $display("FAIL reset_icount got %h want 0", icount); end
        n_vec++; if ({imemREN, dmemREN, dmemWEN, halt} !== 4'b0000) begin n_err++; $display("FAIL reset_reqs got %b want 0000", {imemREN, dmemREN, dmemWEN, halt}); end
        RST = 0; #1;
        n_vec++; if (imemREN !== 1'b1) begin n_err++; $display("FAIL reset_release_imemREN got %b want 1", imemREN); end
    endtask

    task automatic test_sequential();
        idle_inputs(); ihit = 1;
        for (int i = 0; i < 4; i++) begin
            n_vec++; if (imemaddr !== 32'(i * 4) || icount !== 32'(i)) begin
                n_err++; $display("FAIL seq_%0d got pc=%h ic=%0d want pc=%h ic=%0d", i, imemaddr, icount, i * 4, i);
            end
            n_vec++; if (pc_plus4 !== 32'(i * 4 + 4)) begin n_err++; $display("FAIL seq_pc4_%0d got %h want %h", i, pc_plus4, i * 4 + 4); end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_ignored();
        logic [31:0] pc0;
        idle_inputs(); dhit = 1; pc0 = imemaddr;
        tick();
        n_vec++; if (imemaddr !== pc0 || imemREN !== 1'b1 || dmemREN !== 1'b0) begin
            n_err++; $display("FAIL fetch_dhit_ignored got pc=%h iren=%b dren=%b want pc=%h iren=1 dren=0", imemaddr, imemREN, dmemREN, pc0);
        end
        idle_inputs(); ihit = 1; dREN_in = 1;
        tick();
        idle_inputs(); ihit = 1;
        tick(); tick();
        n_vec++; if (imemaddr !== pc0 || dmemREN !== 1'b1 || imemREN !== 1'b0) begin
            n_err++; $display("FAIL mem_ihit_ignored got pc=%h dren=%b iren=%b want pc=%h dren=1 iren=0", imemaddr, dmemREN, imemREN, pc0);
        end
        idle_inputs(); dhit = 1;
        tick();
        idle_inputs();
        n_vec++; if (imemaddr !== m_pc || imemREN !== 1'b1) begin n_err++; $display("FAIL mem_exit got pc=%h want %h", imemaddr, m_pc); end
    endtask

    task automatic test_mem();
        logic [31:0] ic0;
        go_pc(32'h40);
        ic0 = icount;
        ihit = 1; dREN_in = 1;
        tick();
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            n_vec++; if (dmemREN !== 1'b1 || imemREN !== 1'b0 || dmemWEN !== 1'b0 || imemaddr !== 32'h40) begin
                n_err++; $display("FAIL mem_wait_%0d got dren=%b iren=%b dwen=%b pc=%h want 1 0 0 40", i, dmemREN, imemREN, dmemWEN, imemaddr);
            end
            tick();
        end
        dhit = 1;
        tick();
        idle_inputs();
        n_vec++; if (imemaddr !== 32'h44 || icount !== ic0 + 32'd1) begin
            n_err++; $display("FAIL mem_retire got pc=%h ic=%0d want pc=44 ic=%0d", imemaddr, icount, ic0 + 1);
        end
        n_vec++; if (dmemREN !== 1'b0 || imemREN !== 1'b1) begin n_err++; $display("FAIL mem_release got dren=%b iren=%b want 0 1", dmemREN, imemREN); end
    endtask

    task automatic test_pcsrc();
        go_pc(32'h100);
        ihit = 1; PCsrc = 2'd2; imm = 16'hFFFE; tick(); idle_inputs();
        n_vec++; if (imemaddr !== 32'hFC) begin n_err++; $display("FAIL branch_back got %h want 000000fc", imemaddr); end
        go_pc(32'h1000_0000);
        ihit = 1; PCsrc = 2'd1; addr = 26'h40; tick(); idle_inputs();
        n_vec++; if (imemaddr !== 32'h1000_0100) begin n_err++; $display("FAIL jump got %h want 10000100", imemaddr); end
        go_pc(32'h200);
        n_vec++; if (imemaddr !== 32'h200) begin n_err++; $display("FAIL jr got %h want 00000200", imemaddr); end
        go_pc(32'hFFFF_FFFC);
        n_vec++; if (pc_plus4 !== 32'h0) begin n_err++; $display("FAIL wrap_pc4 got %h want 0", pc_plus4); end
        ihit = 1; tick(); idle_inputs();
        n_vec++; if (imemaddr !== 32'h0) begin n_err++; $display("FAIL pc_wrap got %h want 0", imemaddr); end
    endtask

    task automatic test_halt();
        logic [31:0] ic0;
        go_pc(32'h20);
        ic0 = icount;
        ihit = 1; halt_in = 1; tick(); idle_inputs();
        for (int i = 0; i < 10; i++) begin
            n_vec++; if (halt !== 1'b1 || imemaddr !== 32'h20 || icount !== ic0 || {imemREN, dmemREN, dmemWEN} !== 3'b000) begin
                n_err++; $display("FAIL halt_hold_%0d got halt=%b pc=%h ic=%0d reqs=%b want 1 20 %0d 000", i, halt, imemaddr, icount, {imemREN, dmemREN, dmemWEN}, ic0);
            end
            ihit = 1'($urandom); dhit = 1'($urandom); dREN_in = 1'($urandom); PCsrc = 2'($urandom);
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_reset_in_mem();
        RST = 1; tick(); RST = 0;
        go_pc(32'h80);
        ihit = 1; dWEN_in = 1; tick(); idle_inputs();
        n_vec++; if (dmemWEN !== 1'b1) begin n_err++; $display("FAIL store_issue got %b want 1", dmemWEN); end
        RST = 1; #1;
        n_vec++; if ({imemREN, dmemREN, dmemWEN} !== 3'b000) begin n_err++; $display("FAIL reqs_in_rst got %b want 000", {imemREN, dmemREN, dmemWEN}); end
        tick();
        RST = 0; dhit = 1; #1;
        n_vec++; if (imemaddr !== PC_INIT || icount !== 32'd0 || dmemWEN !== 1'b0 || imemREN !== 1'b1) begin
            n_err++; $display("FAIL post_rst got pc=%h ic=%0d dwen=%b iren=%b want %h 0 0 1", imemaddr, icount, dmemWEN, imemREN, PC_INIT);
        end
        tick();
        n_vec++; if (dmemWEN !== 1'b0 || imemaddr !== PC_INIT) begin n_err++; $display("FAIL post_rst_hold got dwen=%b pc=%h want 0 %h", dmemWEN, imemaddr, PC_INIT); end
        idle_inputs();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            RST     = ($urandom_range(0, 39) == 0);
            ihit    = 1'($urandom);
            dhit    = 1'($urandom);
            halt_in = ($urandom_range(0, 15) == 0);
            dREN_in = ($urandom_range(0, 3) == 0);
            dWEN_in = ($urandom_range(0, 3) == 0);
            PCsrc   = 2'($urandom);
            imm     = 16'($urandom);
            addr    = 26'($urandom);
            rdat1   = $urandom & 32'hFFFF_FFFC;
            tick();
            n_vec++; if (imemaddr !== m_pc || icount !== m_ic || pc_plus4 !== m_pc + 32'd4 || halt !== (m_mode == 2)) begin
                n_err++; $display("FAIL rand_state_%0d got pc=%h ic=%0d p4=%h halt=%b want %h %0d %h %b", i, imemaddr, icount, pc_plus4, halt, m_pc, m_ic, m_pc + 32'd4, m_mode == 2);
            end
            n_vec++; if (imemREN !== (!RST && m_mode == 0) || dmemREN !== (!RST && m_mode == 1 && m_rd) || dmemWEN !== (!RST && m_mode == 1 && m_wr)) begin
                n_err++; $display("FAIL rand_reqs_%0d got %b%b%b want %b%b%b", i, imemREN, dmemREN, dmemWEN, !RST && m_mode == 0, !RST && m_mode == 1 && m_rd, !RST && m_mode == 1 && m_wr);
            end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_ignored();
        test_mem();
        test_pcsrc();
        test_halt();
        test_reset_in_mem();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
